// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the up/down counter
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Prescaler register width, never narrower than one bit.
  function automatic int pre_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - counts enabled cycles and ticks once every PRESCALE of them
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear_pre,
  output logic tick
);

  localparam int PW = pre_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear_pre) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - parametrised up/down counter with clamp-load, wrap/saturate and prescaler
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MOD_VALUE = 2 ** WIDTH,
  parameter int SATURATE  = 0,
  parameter int PRESCALE  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_pulse,
  output logic             bound_hit
);

  // Terminal value compared explicitly so a full 2**WIDTH range never relies on overflow.
  localparam logic [WIDTH-1:0] TERM = WIDTH'(MOD_VALUE - 1);
  localparam bit SAT_MODE = (SATURATE == CNT_SAT);

  logic             tick;
  logic             step;
  logic [WIDTH-1:0] step_next;
  logic             step_bound;
  logic [WIDTH-1:0] load_clamped;

  generate
    if (PRESCALE == 1) begin : g_no_pre
      assign tick = 1'b1;
    end else begin : g_pre
      tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .clear_pre (clear || load),
        .tick      (tick)
      );
    end
  endgenerate

  assign step         = enable && tick;
  assign at_max       = (count == TERM);
  assign at_min       = (count == '0);
  assign load_clamped = (load_value > TERM) ? TERM : load_value;

  always_comb begin
    step_next  = count;
    step_bound = 1'b0;
    if (up_down) begin
      if (count == TERM) begin
        step_bound = 1'b1;
        step_next  = SAT_MODE ? count : '0;
      end else begin
        step_next  = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        step_bound = 1'b1;
        step_next  = SAT_MODE ? count : TERM;
      end else begin
        step_next  = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      bound_hit  <= 1'b0;
    end else if (clear) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      bound_hit  <= 1'b0;
    end else if (load) begin
      count      <= load_clamped;
      wrap_pulse <= 1'b0;
    end else if (step) begin
      count      <= step_next;
      wrap_pulse <= step_bound;
      if (step_bound) bound_hit <= 1'b1;
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

endmodule
